// File: rtl/clock_pkg.sv
// State encoding shared by the clock controller and the display mux (blink field select).
// Purely declarative: no logic, no latency.
package clock_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_SET_HR  = 2'd1,
      ST_SET_MIN = 2'd2,
      ST_SET_SEC = 2'd3
   } state_t;

   localparam int DEBOUNCE_DEFAULT = 4;

   // MODE walks RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN; the 2-bit add wraps naturally.
   function automatic state_t next_state(input state_t s);
      return state_t'(s + 2'd1);
   endfunction

endpackage

// File: rtl/key_pulse.sv
// Debounced key-press detector: one-cycle pulse on each accepted rising stable level.
// Pulse appears DEBOUNCE_CYCLES+2 edges after the key settles high; release emits nothing.
module key_pulse #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic CP,
   input  logic nCR,
   input  logic key,
   output logic pulse
);

   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_stable;
   logic          r_pulse;
   logic [CW-1:0] r_cnt;

   // Counter tracks consecutive synced samples disagreeing with the accepted level.
   always_ff @(posedge CP or negedge nCR) begin
      if (!nCR) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_stable <= 1'b0;
         r_pulse  <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_sync1 <= key;
         r_sync2 <= r_sync1;
         r_pulse <= 1'b0;
         if (r_sync2 == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == LAST) begin
            r_cnt    <= '0;
            r_stable <= r_sync2;
            r_pulse  <= r_sync2;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign pulse = r_pulse;

endmodule

// File: rtl/clock_ctrl.sv
// Clock mode FSM plus per-stage count enables; enables are combinational (zero latency from
// tick_1hz / INC pulse), mode and blink are registered and change one edge after a MODE pulse.
module clock_ctrl
   import clock_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic       CP,
   input  logic       nCR,
   input  logic       tick_1hz,
   input  logic       sec_tc,
   input  logic       min_tc,
   input  logic       key_mode,
   input  logic       key_inc,
   output logic       sec_EN,
   output logic       min_EN,
   output logic       hr_EN,
   output logic       sec_clr,
   output logic [1:0] mode,
   output logic       blink
);

   logic   w_mode_p;
   logic   w_inc_p;
   state_t r_state;
   logic   r_blink;

   key_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_mode (
      .CP    (CP),
      .nCR   (nCR),
      .key   (key_mode),
      .pulse (w_mode_p)
   );

   key_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_inc (
      .CP    (CP),
      .nCR   (nCR),
      .key   (key_inc),
      .pulse (w_inc_p)
   );

   // Entering a SET state forces blink on, even if a tick lands on the same edge.
   always_ff @(posedge CP or negedge nCR) begin
      if (!nCR) begin
         r_state <= ST_RUN;
         r_blink <= 1'b0;
      end else if (w_mode_p) begin
         r_state <= next_state(r_state);
         r_blink <= (next_state(r_state) != ST_RUN);
      end else if ((r_state != ST_RUN) && tick_1hz) begin
         r_blink <= ~r_blink;
      end
   end

   // INC acts on the pre-transition state; SET states never let tick_1hz through.
   always_comb begin
      sec_EN  = 1'b0;
      min_EN  = 1'b0;
      hr_EN   = 1'b0;
      sec_clr = 1'b0;
      case (r_state)
         ST_RUN: begin
            sec_EN = tick_1hz;
            min_EN = tick_1hz & sec_tc;
            hr_EN  = tick_1hz & sec_tc & min_tc;
         end
         ST_SET_HR:  hr_EN   = w_inc_p;
         ST_SET_MIN: min_EN  = w_inc_p;
         ST_SET_SEC: sec_clr = w_inc_p;
         default: ;
      endcase
   end

   assign mode  = r_state;
   assign blink = r_blink;

endmodule
